// File: rtl/otg_hpi_responder_if.sv
// HPI strobe bus between a host (Nios PIO side) and the responder.
//   hpi_addr     register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   hpi_cs_n     chip select, active low
//   hpi_r_n      read strobe, active low
//   hpi_w_n      write strobe, active low
//   hpi_data_in  write data, host -> responder
//   hpi_data_out read data, responder -> host
//   hpi_data_oe  responder is driving hpi_data_out
//   hpi_int      interrupt to host (local->host mailbox full)
interface otg_hpi_responder_if;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n;
  logic        hpi_r_n;
  logic        hpi_w_n;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic        hpi_int;

  modport master (
    output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_in,
    input  hpi_data_out, hpi_data_oe, hpi_int
  );

  modport slave (
    input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_in,
    output hpi_data_out, hpi_data_oe, hpi_int
  );
endinterface

// File: rtl/otg_hpi_responder.sv
// Target-side stand-in for the OTG controller host-port interface.
// A 16-bit word RAM sits behind an auto-incrementing byte address register,
// with a bidirectional mailbox and a status register.
//   clk_clk        system clock, HPI inputs synchronous to it
//   reset_reset_n  asynchronous active-low reset
//   hpi            HPI strobe bus (slave modport)
//   mbx_in_data    last host-written mailbox word
//   mbx_in_valid   host->local mailbox full
//   mbx_in_ack     local consumer pops host->local mailbox
//   mbx_out_data   word to post to host
//   mbx_out_wr     post mbx_out_data (single-cycle pulse)
//   mbx_out_busy   local->host mailbox full, posts ignored
//
// state    | meaning
// S_DISARM | after reset, waiting for a cycle with cs_n high; strobes ignored
// S_IDLE   | armed, no strobe active last cycle
// S_RD     | read strobe was active last cycle
// S_WR     | write strobe was active last cycle
module otg_hpi_responder #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] BASE_ADDR = 16'h1000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  otg_hpi_responder_if.slave      hpi,
  output logic [15:0]             mbx_in_data,
  output logic                    mbx_in_valid,
  input  logic                    mbx_in_ack,
  input  logic [15:0]             mbx_out_data,
  input  logic                    mbx_out_wr,
  output logic                    mbx_out_busy
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [16:0] SPAN  = 17'(2 * DEPTH);

  localparam logic [1:0] SEL_DATA = 2'd0;
  localparam logic [1:0] SEL_MBX  = 2'd1;
  localparam logic [1:0] SEL_ADDR = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  typedef enum logic [1:0] {S_DISARM, S_IDLE, S_RD, S_WR} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] out_q, out_d;
  logic        oe_q, oe_d;
  logic [1:0]  rd_sel_q, rd_sel_d;
  logic [15:0] in_data_q, in_data_d;
  logic        in_valid_q, in_valid_d;
  logic        ovr_q, ovr_d;
  logic        busy_q, busy_d;
  logic [15:0] latch_q, latch_d;

  logic [15:0] mem [DEPTH];

  logic              rd_act, wr_act, armed;
  logic              rd_start, rd_end, wr_start;
  logic [16:0]       off;
  logic              in_win;
  logic [ADDR_W-1:0] word;
  logic              ram_we;
  logic [15:0]       rd_mux;
  logic [15:0]       a_inc;

  // Both strobes low is illegal and counts as inactive.
  assign rd_act = ~hpi.hpi_cs_n & ~hpi.hpi_r_n &  hpi.hpi_w_n;
  assign wr_act = ~hpi.hpi_cs_n & ~hpi.hpi_w_n &  hpi.hpi_r_n;
  assign armed  = (state_q != S_DISARM);

  assign rd_start = armed & rd_act & (state_q != S_RD);
  assign rd_end   = (state_q == S_RD) & ~rd_act;
  assign wr_start = armed & wr_act & (state_q != S_WR);

  // A below BASE borrows into bit 16, so the single compare covers both bounds.
  assign off    = {1'b0, a_q} - {1'b0, BASE_ADDR};
  assign in_win = (off < SPAN);
  assign word   = ADDR_W'(off >> 1);
  assign a_inc  = a_q + 16'd2;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    out_d      = out_q;
    oe_d       = oe_q;
    rd_sel_d   = rd_sel_q;
    in_data_d  = in_data_q;
    in_valid_d = in_valid_q;
    ovr_d      = ovr_q;
    busy_d     = busy_q;
    latch_d    = latch_q;
    ram_we     = 1'b0;
    rd_mux     = 16'h0000;

    case (state_q)
      S_DISARM: if (hpi.hpi_cs_n) state_d = S_IDLE;
      default: begin
        if (rd_act)      state_d = S_RD;
        else if (wr_act) state_d = S_WR;
        else             state_d = S_IDLE;
      end
    endcase

    case (hpi.hpi_addr)
      SEL_DATA: rd_mux = in_win ? mem[word] : 16'h0000;
      SEL_MBX:  rd_mux = latch_q;
      SEL_ADDR: rd_mux = a_q;
      default:  rd_mux = {13'b0, ovr_q, in_valid_q, busy_q};
    endcase

    if (rd_start) begin
      out_d    = rd_mux;
      oe_d     = 1'b1;
      rd_sel_d = hpi.hpi_addr;
    end

    if (rd_end) begin
      oe_d = 1'b0;
      case (rd_sel_q)
        SEL_DATA: a_d    = a_inc;
        SEL_MBX:  busy_d = 1'b0;
        SEL_STAT: ovr_d  = 1'b0;
        default: ;
      endcase
    end

    // A host read draining the outbound mailbox beats a same-cycle post.
    if (mbx_out_wr && !busy_q && !(rd_end && rd_sel_q == SEL_MBX)) begin
      busy_d  = 1'b1;
      latch_d = mbx_out_data;
    end

    if (mbx_in_ack && in_valid_q) in_valid_d = 1'b0;

    if (wr_start) begin
      case (hpi.hpi_addr)
        SEL_DATA: begin
          ram_we = in_win;
          a_d    = a_inc;
        end
        SEL_ADDR: a_d = hpi.hpi_data_in & 16'hFFFE;
        SEL_MBX: begin
          in_data_d  = hpi.hpi_data_in;
          in_valid_d = 1'b1;
          if (in_valid_q && !mbx_in_ack) ovr_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= S_DISARM;
      a_q        <= 16'h0000;
      out_q      <= 16'h0000;
      oe_q       <= 1'b0;
      rd_sel_q   <= SEL_DATA;
      in_data_q  <= 16'h0000;
      in_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      latch_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      rd_sel_q   <= rd_sel_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
      latch_q    <= latch_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (ram_we) mem[word] <= hpi.hpi_data_in;
  end

  assign hpi.hpi_data_out = out_q;
  assign hpi.hpi_data_oe  = oe_q;
  assign hpi.hpi_int      = busy_q;
  assign mbx_in_data      = in_data_q;
  assign mbx_in_valid     = in_valid_q;
  assign mbx_out_busy     = busy_q;

endmodule
